// File: rtl/wired_inst_queue_pkg.sv
// Shared types for the decoder-to-rename instruction queue.
// Stand-in for the pipeline bundle normally supplied by wired0_defines.svh.
package wired_inst_queue_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } pipeline_ctrl_pack_t;

  function automatic logic [1:0] pop2(input logic [1:0] m);
    return {1'b0, m[0]} + {1'b0, m[1]};
  endfunction

endpackage

// File: rtl/wired_inst_queue.sv
// Two-wide in / two-wide out instruction queue with compaction.
// in_ready depends only on registered occupancy to cut the ready path.
module wired_inst_queue
  import wired_inst_queue_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [1:0]          in_mask_i,
  input  pipeline_ctrl_pack_t in_pkg_i [2],
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [1:0]          out_mask_o,
  output pipeline_ctrl_pack_t out_pkg_o [2]
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  pipeline_ctrl_pack_t mem [DEPTH];

  logic             enq;
  logic             deq;
  logic [1:0]       n_in;
  logic [1:0]       n_out;
  logic [PTR_W-1:0] tail_p1;
  logic [PTR_W-1:0] head_p1;
  logic             wr_a;
  logic             wr_b;
  pipeline_ctrl_pack_t data_a;

  assign in_ready_o = count <= CNT_W'(DEPTH - 2);

  assign enq  = in_valid_i & in_ready_o & ~flush_i;
  assign n_in = enq ? pop2(in_mask_i) : 2'd0;

  assign tail_p1 = tail + PTR_W'(1);
  assign head_p1 = head + PTR_W'(1);

  // Port A takes the oldest valid slot; port B only for a full pair.
  assign wr_a   = enq & (|in_mask_i);
  assign wr_b   = enq & (&in_mask_i);
  assign data_a = in_mask_i[0] ? in_pkg_i[0] : in_pkg_i[1];

  assign out_mask_o = {count >= CNT_W'(2), count != '0} & {2{~flush_i}};
  assign out_valid_o = (count != '0) & ~flush_i;
  assign out_pkg_o[0] = mem[head];
  assign out_pkg_o[1] = mem[head_p1];

  assign deq   = out_valid_o & out_ready_i;
  assign n_out = deq ? pop2(out_mask_o) : 2'd0;

  always_ff @(posedge clk) begin
    if (wr_a) mem[tail] <= data_a;
    if (wr_b) mem[tail_p1] <= in_pkg_i[1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(n_out);
      tail  <= tail + PTR_W'(n_in);
      count <= count + CNT_W'(n_in) - CNT_W'(n_out);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (count <= CNT_W'(DEPTH));
      assert (!(enq && !in_ready_o));
      assert (out_mask_o != 2'b10);
    end
  end

endmodule
